// File: rtl/ip_reg_pkg.sv
// Shared types and constants for the IP-side register responder.
package ip_reg_pkg;

  typedef enum logic [1:0] {
    REG_RW,
    REG_RO,
    REG_CNT,
    REG_OOR
  } reg_region_e;

  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;
  localparam logic [31:0] OOR_RDATA = 32'h0;

  // Merge write data into an existing word, one byte lane per enable bit.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_counter.sv
// Saturating 32-bit event counter with clear-on-read; an increment in the clear cycle survives.
module reg_counter
  import ip_reg_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= inc ? 32'd1 : 32'd0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ip_reg_responder.sv
// IP-clock-domain register responder: RW registers, sampled RO inputs and event counters,
// answering every accepted request with a single ack one cycle later.
module ip_reg_responder
  import ip_reg_pkg::*;
#(
  parameter int unsigned                    C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                    C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter int unsigned                    NUM_RW             = 4,
  parameter int unsigned                    NUM_RO             = 4,
  parameter int unsigned                    NUM_CNT            = 4,
  parameter logic [NUM_RW*32-1:0]           RW_RESET_VAL       = '0,
  parameter bit                             CNT_CLR_ON_READ    = 1'b1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] bus2ip_addr_sync,
  input  logic                          bus2ip_cs_sync,
  input  logic                          bus2ip_rnw_sync,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] bus2ip_data_sync,
  input  logic [3:0]                    bus2ip_be_sync,
  input  logic                          bus2ip_sync_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ip2bus_data_sync,
  output logic                          ip2bus_rdack_sync,
  output logic                          ip2bus_wrack_sync,
  output logic                          ip2bus_error_sync,
  output logic [NUM_RW*32-1:0]          rw_regs,
  input  logic [NUM_RO*32-1:0]          ro_regs,
  input  logic [NUM_CNT-1:0]            cnt_inc
);

  localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned RO_BASE  = NUM_RW;
  localparam int unsigned CNT_BASE = NUM_RW + NUM_RO;
  localparam int unsigned TOTAL    = NUM_RW + NUM_RO + NUM_CNT;

  logic                 rd_req;
  logic                 wr_req;
  logic [AW-1:0]        off;
  reg_region_e          region;
  logic [NUM_RW-1:0]    rw_hit;
  logic [NUM_RO-1:0]    ro_hit;
  logic [NUM_CNT-1:0]   cnt_hit;
  logic [NUM_CNT-1:0]   cnt_clr;
  logic [31:0]          cnt_val [NUM_CNT];
  logic [31:0]          rd_data;
  logic                 err_d;

  logic [NUM_RW*32-1:0] rw_q;
  logic                 rdack_q;
  logic                 wrack_q;
  logic                 err_q;
  logic [31:0]          data_q;

  // Decode stage
  always_comb begin
    rd_req = bus2ip_sync_valid & bus2ip_cs_sync & bus2ip_rnw_sync;
    wr_req = bus2ip_sync_valid & bus2ip_cs_sync & ~bus2ip_rnw_sync;
    off    = (bus2ip_addr_sync - C_BASE_ADDR) >> 2;
    region = REG_OOR;
    if ((bus2ip_addr_sync >= C_BASE_ADDR) && (off < AW'(TOTAL))) begin
      if (off < AW'(RO_BASE)) begin
        region = REG_RW;
      end else if (off < AW'(CNT_BASE)) begin
        region = REG_RO;
      end else begin
        region = REG_CNT;
      end
    end

    for (int i = 0; i < int'(NUM_RW); i++) begin
      rw_hit[i] = (region == REG_RW) && (off == AW'(i));
    end
    for (int i = 0; i < int'(NUM_RO); i++) begin
      ro_hit[i] = (region == REG_RO) && (off == AW'(RO_BASE + i));
    end
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      cnt_hit[i] = (region == REG_CNT) && (off == AW'(CNT_BASE + i));
      cnt_clr[i] = rd_req && cnt_hit[i] && CNT_CLR_ON_READ;
    end

    rd_data = '0;
    for (int i = 0; i < int'(NUM_RW); i++) begin
      if (rw_hit[i]) rd_data |= rw_q[32*i +: 32];
    end
    for (int i = 0; i < int'(NUM_RO); i++) begin
      if (ro_hit[i]) rd_data |= ro_regs[32*i +: 32];
    end
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      if (cnt_hit[i]) rd_data |= cnt_val[i];
    end
    if (region == REG_OOR) rd_data = OOR_RDATA;

    // Reads fault only out of range; writes fault anywhere outside the RW window.
    err_d = rd_req ? (region == REG_OOR) : (wr_req && (region != REG_RW));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rw_q <= RW_RESET_VAL;
    end else if (wr_req) begin
      for (int i = 0; i < int'(NUM_RW); i++) begin
        if (rw_hit[i]) begin
          rw_q[32*i +: 32] <= apply_be(rw_q[32*i +: 32], bus2ip_data_sync, bus2ip_be_sync);
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CNT); g++) begin : g_cnt
    reg_counter u_cnt (
      .clk   (clk),
      .resetn(resetn),
      .inc   (cnt_inc[g]),
      .clr   (cnt_clr[g]),
      .count (cnt_val[g])
    );
  end

  // Response stage; an async reset drops any ack still in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdack_q <= 1'b0;
      wrack_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      rdack_q <= rd_req;
      wrack_q <= wr_req;
      err_q   <= err_d;
      data_q  <= rd_req ? rd_data : 32'h0;
    end
  end

  assign rw_regs           = rw_q;
  assign ip2bus_rdack_sync = rdack_q;
  assign ip2bus_wrack_sync = wrack_q;
  assign ip2bus_error_sync = err_q;
  assign ip2bus_data_sync  = data_q;

endmodule

// File: tb/tb_ip_reg_responder.sv
// Randomised bench for ip_reg_responder against a word-level register-map model.
module tb_ip_reg_responder;

  localparam logic [31:0]  BASE    = 32'h0000_0100;
  localparam logic [127:0] RST_VAL = {32'hCAFE_0003, 32'h0000_0002, 32'h8000_0001, 32'h0};

  logic         clk = 1'b0;
  logic         resetn;
  logic [31:0]  addr;
  logic         cs, rnw, valid;
  logic [31:0]  wdata;
  logic [3:0]   be;
  logic [31:0]  rdata;
  logic         rdack, wrack, err;
  logic [127:0] rw_regs;
  logic [127:0] ro_regs;
  logic [3:0]   cnt_inc;

  int checks = 0;
  int errors = 0;

  // Model state and expected response
  logic [127:0] rst_vec = RST_VAL;
  logic [31:0]  m_rw  [4];
  logic [31:0]  m_cnt [4];
  logic         exp_rd, exp_wr, exp_err;
  logic [31:0]  exp_data;

  ip_reg_responder #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .C_BASE_ADDR       (BASE),
    .NUM_RW            (4),
    .NUM_RO            (4),
    .NUM_CNT           (4),
    .RW_RESET_VAL      (RST_VAL),
    .CNT_CLR_ON_READ   (1'b1)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .bus2ip_addr_sync (addr),
    .bus2ip_cs_sync   (cs),
    .bus2ip_rnw_sync  (rnw),
    .bus2ip_data_sync (wdata),
    .bus2ip_be_sync   (be),
    .bus2ip_sync_valid(valid),
    .ip2bus_data_sync (rdata),
    .ip2bus_rdack_sync(rdack),
    .ip2bus_wrack_sync(wrack),
    .ip2bus_error_sync(err),
    .rw_regs          (rw_regs),
    .ro_regs          (ro_regs),
    .cnt_inc          (cnt_inc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [127:0] model_rw_vec();
    return {m_rw[3], m_rw[2], m_rw[1], m_rw[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_rw[i]  = rst_vec[32*i +: 32];
      m_cnt[i] = 32'h0;
    end
    exp_rd = 0; exp_wr = 0; exp_err = 0; exp_data = 0;
  endtask

  // One bus cycle of the register map, from the inputs present at this clock edge.
  task automatic model_step();
    bit oor;
    int o;
    bit clr [4];
    exp_rd = 0; exp_wr = 0; exp_err = 0; exp_data = 0;
    for (int i = 0; i < 4; i++) clr[i] = 0;
    if (valid && cs) begin
      oor = (addr < BASE) || (((addr - BASE) / 4) >= 12);
      o   = oor ? 0 : int'((addr - BASE) / 4);
      if (rnw) begin
        exp_rd = 1;
        if (oor) exp_err = 1;
        else if (o < 4) exp_data = m_rw[o];
        else if (o < 8) exp_data = ro_regs[32*(o-4) +: 32];
        else begin
          exp_data = m_cnt[o-8];
          clr[o-8] = 1;
        end
      end else begin
        exp_wr = 1;
        if (oor || o >= 4) exp_err = 1;
        else for (int k = 0; k < 4; k++) if (be[k]) m_rw[o][8*k +: 8] = wdata[8*k +: 8];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (clr[i]) m_cnt[i] = cnt_inc[i] ? 32'd1 : 32'd0;
      else if (cnt_inc[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("rdack", 128'(rdack), 128'(exp_rd));
        chk("wrack", 128'(wrack), 128'(exp_wr));
        chk("error", 128'(err), 128'(exp_err));
        chk("rdata", 128'(rdata), 128'(exp_data));
        chk("rw_regs", rw_regs, model_rw_vec());
      end else begin
        chk("rst_acks", {125'(0), rdack, wrack, err}, 128'(0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        chk("rst_rw_regs", rw_regs, rst_vec);
      end
    end
  end

  task automatic drive(input bit v, input bit c, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [3:0] inc);
    @(posedge clk);
    #1;
    valid = v; cs = c; rnw = r; addr = a; wdata = d; be = b; cnt_inc = inc;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0);
  endtask

  // Single request, then idle; returns the response seen in the following cycle.
  task automatic txn(input bit r, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic o_rd, output logic o_wr,
                     output logic o_err, output logic [31:0] o_data);
    drive(1, 1, r, a, d, b, 4'h0);
    idle();
    @(negedge clk);
    o_rd = rdack; o_wr = wrack; o_err = err; o_data = rdata;
  endtask

  logic        t_rd, t_wr, t_err;
  logic [31:0] t_data;
  int          ack_cnt;

  initial begin
    resetn = 1'b0;
    valid = 0; cs = 0; rnw = 0; addr = 0; wdata = 0; be = 0; cnt_inc = 0;
    ro_regs = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;

    // Reset defaults of the RW registers
    for (int i = 0; i < 4; i++) begin
      txn(1, BASE + 32'(4*i), 32'h0, 4'h0, t_rd, t_wr, t_err, t_data);
      chk("reset_read_ack", 128'(t_rd), 128'(1));
      chk("reset_read_data", 128'(t_data), 128'(rst_vec[32*i +: 32]));
    end
    chk("reset_read_err", 128'(t_err), 128'(0));

    // Byte-enable write
    txn(0, BASE, 32'h0, 4'hF, t_rd, t_wr, t_err, t_data);
    txn(0, BASE + 32'd1, 32'hAABB_CCDD, 4'b0101, t_rd, t_wr, t_err, t_data);
    chk("byte_wrack", 128'(t_wr), 128'(1));
    chk("byte_rw0", 128'(rw_regs[31:0]), 128'(32'h00BB_00DD));
    chk("byte_model_rw0", 128'(m_rw[0]), 128'(32'h00BB_00DD));

    // Write then read back-to-back
    drive(1, 1, 0, BASE + 32'd4, 32'h1234_5678, 4'hF, 4'h0);
    drive(1, 1, 1, BASE + 32'd4, 32'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("b2b_wrack", 128'(wrack), 128'(1));
    idle();
    @(negedge clk);
    chk("b2b_rdack", 128'(rdack), 128'(1));
    chk("b2b_rdata", 128'(rdata), 128'(32'h1234_5678));

    // RO sample
    txn(1, BASE + 32'd20, 32'h0, 4'h0, t_rd, t_wr, t_err, t_data);
    chk("ro_read", 128'(t_data), 128'(32'h2222_2222));

    // Counter: five events, clear-on-read with a coincident event
    repeat (5) drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h1);
    drive(1, 1, 1, BASE + 32'd32, 32'h0, 4'h0, 4'h1);
    drive(1, 1, 1, BASE + 32'd32, 32'h0, 4'h0, 4'h0);
    @(negedge clk);
    chk("cnt_first", 128'(rdata), 128'(5));
    idle();
    @(negedge clk);
    chk("cnt_second", 128'(rdata), 128'(1));

    // Error responses
    txn(0, BASE + 32'd16, 32'hFFFF_FFFF, 4'hF, t_rd, t_wr, t_err, t_data);
    chk("ro_write_ack_err", {t_wr, t_err}, 128'(2'b11));
    txn(1, BASE + 32'd48, 32'h0, 4'h0, t_rd, t_wr, t_err, t_data);
    chk("oor_read_ack_err", {t_rd, t_err}, 128'(2'b11));
    chk("oor_read_data", 128'(t_data), 128'(0));
    txn(1, BASE - 32'd4, 32'h0, 4'h0, t_rd, t_wr, t_err, t_data);
    chk("below_base_err", {t_rd, t_err}, 128'(2'b11));

    // Valid without chip select is idle
    ack_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 1'($urandom), BASE + 32'(4*$urandom_range(0, 11)), $urandom, 4'hF, 4'h0);
      @(negedge clk);
      ack_cnt += int'(rdack) + int'(wrack);
    end
    chk("idle_no_acks", 128'(ack_cnt), 128'(0));

    // Reset arriving with a request pending
    drive(1, 1, 0, BASE + 32'd8, 32'h5555_5555, 4'hF, 4'h0);
    #2 resetn = 1'b0;
    idle();
    #2 resetn = 1'b1;
    ack_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      ack_cnt += int'(rdack) + int'(wrack);
    end
    chk("reset_drops_ack", 128'(ack_cnt), 128'(0));
    chk("reset_rw2", 128'(rw_regs[95:64]), 128'(32'h0000_0002));

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE - 32'(4 * $urandom_range(1, 4));
        2, 3:    a = BASE + 32'(4 * $urandom_range(8, 11));
        default: a = BASE + 32'(4 * $urandom_range(0, 13)) + 32'($urandom_range(0, 3));
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'($urandom), a, $urandom,
            4'($urandom), 4'($urandom));
      ro_regs = {$urandom, $urandom, $urandom, $urandom};
    end
    idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
